// File: rtl/init_reset_sequencer_pkg.sv
// Shared definitions for the INIT reset sequencer: state encoding and output decode.
// Monitoring and debug logic import the same package so they all agree on the state numbering.
package init_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_WAIT_LOCK  = 3'd3,
        ST_STRETCH    = 3'd4,
        ST_RUN        = 3'd5,
        ST_FAULT      = 3'd6
    } state_t;

    typedef struct packed {
        logic fabric_reset_n;
        logic init_ok;
        logic timeout;
    } outs_t;

    function automatic outs_t decode_outputs(input state_t s);
        outs_t o;
        o.fabric_reset_n = (s == ST_RUN);
        o.init_ok        = (s == ST_RUN);
        o.timeout        = (s == ST_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/init_reset_sequencer_sync_chain.sv
// N-bit, STAGES-deep synchroniser for asynchronous status inputs.
// A synchronous clear flushes every stage so that a reset discards any half-captured history.
module init_sync_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (clear) begin
            stage <= '{default: '0};
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/init_reset_sequencer.sv
// Sequences the synchronised INIT monitor status into one stretched fabric reset release,
// with a sticky fault when device init, calibration or lock stalls for too long.
//
// state      | meaning
// IDLE       | waiting for power-on reset to deassert
// WAIT_INIT  | waiting for device init done (wait timer running)
// WAIT_CALIB | waiting for HSIO bank 1 calibration (wait timer running)
// WAIT_LOCK  | waiting for PLL lock (wait timer running)
// STRETCH    | calib and lock must stay high before release
// RUN        | fabric reset released, INIT_OK high
// FAULT      | a wait state timed out; sticky until RESET or POR low
module init_reset_sequencer
    import init_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FABRIC_POR_N,
    input  logic       DEVICE_INIT_DONE,
    input  logic       BANK_1_CALIB_STATUS,
    input  logic       PLL_LOCK,
    output logic       FABRIC_RESET_N,
    output logic       INIT_OK,
    output logic       TIMEOUT,
    output logic [2:0] STATE
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that saw lock_s high is the first held cycle, so STRETCH covers the rest.
    localparam logic [CNT_W-1:0] STRETCH_LAST =
        CNT_W'((STRETCH_CYCLES > 1) ? (STRETCH_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0] sync_q;
    logic       por_s, init_s, cal_s, lock_s;

    init_sync_chain #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (CLK),
        .clear (RESET),
        .d     ({PLL_LOCK, BANK_1_CALIB_STATUS, DEVICE_INIT_DONE, FABRIC_POR_N}),
        .q     (sync_q)
    );

    assign {lock_s, cal_s, init_s, por_s} = sync_q;

    state_t           state, state_next;
    logic [CNT_W-1:0] timer, timer_next;
    logic [CNT_W-1:0] stretch_cnt, stretch_next;
    outs_t            outs, outs_next;
    logic             timer_expired;
    logic             held;

    assign timer_expired = (timer >= TIMER_LAST);
    assign held          = cal_s && lock_s;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            timer       <= '0;
            stretch_cnt <= '0;
            outs        <= '0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            stretch_cnt <= stretch_next;
            outs        <= outs_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        stretch_next = stretch_cnt;
        if (!por_s) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_next = ST_WAIT_INIT;
                    timer_next = '0;
                end
                ST_WAIT_INIT, ST_WAIT_CALIB, ST_WAIT_LOCK: begin
                    // Saturate so a late wait state still sees an expired timer.
                    if (timer != '1) timer_next = timer + CNT_ONE;
                    if (state == ST_WAIT_INIT && init_s) begin
                        state_next = ST_WAIT_CALIB;
                    end else if (state == ST_WAIT_CALIB && cal_s) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (state == ST_WAIT_LOCK && lock_s) begin
                        state_next   = ST_STRETCH;
                        stretch_next = '0;
                    end else if (timer_expired) begin
                        state_next = ST_FAULT;
                    end
                end
                ST_STRETCH: begin
                    if (!held) begin
                        state_next = ST_IDLE;
                    end else if (stretch_cnt == STRETCH_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        stretch_next = stretch_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!held) state_next = ST_IDLE;
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        outs_next = decode_outputs(state_next);
    end

    assign STATE          = state;
    assign FABRIC_RESET_N = outs.fabric_reset_n;
    assign INIT_OK        = outs.init_ok;
    assign TIMEOUT        = outs.timeout;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Scoreboard bench for init_reset_sequencer: each scenario queues the expected
// {STATE, FABRIC_RESET_N, INIT_OK, TIMEOUT} per absolute cycle, and a negedge monitor pops and compares.
module tb_init_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       por_n = 1'b0;
    logic       init_done = 1'b0;
    logic       calib = 1'b0;
    logic       lock = 1'b0;
    logic       fabric_reset_n;
    logic       init_ok;
    logic       timeout;
    logic [2:0] state;

    init_reset_sequencer #(
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (16),
        .TIMEOUT_CYCLES (100),
        .CNT_W          (16)
    ) dut (
        .CLK                 (clk),
        .RESET               (rst),
        .FABRIC_POR_N        (por_n),
        .DEVICE_INIT_DONE    (init_done),
        .BANK_1_CALIB_STATUS (calib),
        .PLL_LOCK            (lock),
        .FABRIC_RESET_N      (fabric_reset_n),
        .INIT_OK             (init_ok),
        .TIMEOUT             (timeout),
        .STATE               (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [5:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s @cyc %0d: got state=%0d rst_n=%b ok=%b to=%b, want state=%0d rst_n=%b ok=%b to=%b",
                     tag, cyc, obs[5:3], obs[2], obs[1], obs[0],
                     expv[5:3], expv[2], expv[1], expv[0]);
        end
    endtask

    task automatic expect_at(input int c, input string tag, input logic [2:0] st,
                             input logic rn, input logic ok, input logic to);
        exp_t e;
        e.cyc = c;
        e.tag = tag;
        e.val = {st, rn, ok, to};
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic p, input logic i, input logic c, input logic l);
        por_n     = p;
        init_done = i;
        calib     = c;
        lock      = l;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        expect_at(cyc + 1, "reset_state", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                chk(e.tag, {state, fabric_reset_n, init_ok, timeout}, e.val);
            end
        end
    end

    initial begin : stimulus
        int t0;
        int t2;
        int budget;

        tick(1);
        apply_reset();

        // Nominal release
        t0 = cyc;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        expect_at(t0 + 3,  "nom_wait_init",  3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 4,  "nom_wait_calib", 3'd2, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 5,  "nom_wait_lock",  3'd3, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 6,  "nom_stretch",    3'd4, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 20, "nom_stretch_end",3'd4, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 21, "nom_run",        3'd5, 1'b1, 1'b1, 1'b0);
        tick(24);

        // Calibration loss in RUN
        t0 = cyc;
        calib = 1'b0;
        expect_at(t0 + 2, "runloss_still_run", 3'd5, 1'b1, 1'b1, 1'b0);
        expect_at(t0 + 3, "runloss_idle",      3'd0, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 4, "runloss_restart",   3'd1, 1'b0, 1'b0, 1'b0);
        tick(6);

        apply_reset();

        // One-cycle lock drop at stretch count 8
        t0 = cyc;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        expect_at(t0 + 14, "abort_stretch8",   3'd4, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 15, "abort_idle",       3'd0, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 16, "abort_wait_init",  3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 33, "abort_no_early",   3'd4, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 34, "abort_run",        3'd5, 1'b1, 1'b1, 1'b0);
        tick(12);
        lock = 1'b0;
        tick(1);
        lock = 1'b1;
        tick(24);

        apply_reset();

        // Device init never completes
        t0 = cyc;
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        expect_at(t0 + 102, "to_last_wait",  3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 103, "to_fault",      3'd6, 1'b0, 1'b0, 1'b1);
        tick(110);
        t2 = cyc;
        expect_at(t2 + 2,   "to_sticky",     3'd6, 1'b0, 1'b0, 1'b1);
        expect_at(t2 + 3,   "to_cleared",    3'd0, 1'b0, 1'b0, 1'b0);
        expect_at(t2 + 4,   "to_rewait",     3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t2 + 103, "to_timer_clr",  3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t2 + 104, "to_fault_again",3'd6, 1'b0, 1'b0, 1'b1);
        por_n = 1'b0;
        tick(1);
        por_n = 1'b1;
        tick(106);

        apply_reset();

        // init_s lands on the timer=99 cycle: the condition wins
        t0 = cyc;
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        expect_at(t0 + 102, "coin_wait_init", 3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 103, "coin_calib",     3'd2, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 104, "coin_lock",      3'd3, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 105, "coin_stretch",   3'd4, 1'b0, 1'b0, 1'b0);
        tick(100);
        init_done = 1'b1;
        tick(10);

        apply_reset();

        // RESET pulse during STRETCH flushes the synchroniser
        t0 = cyc;
        set_in(1'b1, 1'b1, 1'b1, 1'b1);
        expect_at(t0 + 10, "mid_stretch",   3'd4, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 11, "mid_reset",     3'd0, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 12, "mid_flush1",    3'd0, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 13, "mid_flush2",    3'd0, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 14, "mid_restart",   3'd1, 1'b0, 1'b0, 1'b0);
        expect_at(t0 + 32, "mid_run",       3'd5, 1'b1, 1'b1, 1'b0);
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(25);

        budget = 200;
        while (sb.size() > 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("scoreboard_drained", 6'(sb.size()), 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want finish before limit");
        $fatal(1);
    end

endmodule
